edge_pixel_streamer: RTL and testbench

- Transmit side of the gray-image pixel interface into the edge detector datapath.
- Host CPU loads one IMG_X_SIZE x IMG_Y_SIZE gray frame through an Avalon-MM slave into an internal frame buffer.
- On START, the block streams the frame row-major to the detector using a valid/ack handshake.
- Reports load/stream status back over the same slave.

---
 rtl/edge_pixel_streamer_if.sv | 26 ++
 rtl/edge_pixel_streamer.sv | 214 +++++++++++++++++++++
 tb/tb_edge_pixel_streamer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/edge_pixel_streamer_if.sv
// Bus bundle for edge_pixel_streamer: the Avalon-MM register slave plus the
// valid/ack pixel stream toward the edge detector.
// slave  : view of the streamer itself.
// master : view of the host / detector side (testbench, integration shell).
interface edge_pixel_streamer_if;
  logic [1:0]  avs_address_i;
  logic        avs_write_i;
  logic [31:0] avs_writedata_i;
  logic        avs_read_i;
  logic [31:0] avs_readdata_o;
  logic [7:0]  GrayImg_o;
  logic        dataAvailable_o;
  logic        dataAck_i;
  logic        frameStart_o;
  logic        frameEnd_o;

  modport slave (
    input  avs_address_i, avs_write_i, avs_writedata_i, avs_read_i, dataAck_i,
    output avs_readdata_o, GrayImg_o, dataAvailable_o, frameStart_o, frameEnd_o
  );

  modport master (
    output avs_address_i, avs_write_i, avs_writedata_i, avs_read_i, dataAck_i,
    input  avs_readdata_o, GrayImg_o, dataAvailable_o, frameStart_o, frameEnd_o
  );
endinterface

// File: rtl/edge_pixel_streamer.sv
// edge_pixel_streamer: host loads one gray frame through the register slave
// into a local buffer; START streams it row-major to the edge detector with a
// valid/ack handshake.
// Optional build macro EDGE_STREAMER_PACK4_EN: each PIXEL write carries four
// little-endian pixels (byte0 stored first) instead of one.
module edge_pixel_streamer #(
  parameter int IMG_X_SIZE = 100,
  parameter int IMG_Y_SIZE = 100
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  edge_pixel_streamer_if.slave bus
);

  localparam int N            = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int IMG_ADR_BITS = $clog2(N);
  // Counters must be able to hold the value N itself (a full frame), which
  // needs one more bit than the buffer address when N is a power of two.
  localparam int CNT_BITS     = $clog2(N + 1);
  localparam int SUM_BITS     = CNT_BITS + 2;
`ifdef EDGE_STREAMER_PACK4_EN
  localparam int LANES        = 4;
`else
  localparam int LANES        = 1;
`endif

  localparam logic [CNT_BITS-1:0] N_C    = CNT_BITS'(N);
  localparam logic [CNT_BITS-1:0] LAST_C = CNT_BITS'(N - 1);
  localparam logic [CNT_BITS-1:0] ZERO_C = CNT_BITS'(0);
  localparam logic [CNT_BITS-1:0] ONE_C  = CNT_BITS'(1);
  localparam logic [SUM_BITS-1:0] N_SUM  = SUM_BITS'(N);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_PIXEL  = 2'd2;
  localparam logic [1:0] REG_SENT   = 2'd3;

  logic [7:0]              mem [N];
  logic [1:0]              state_q, state_d;
  logic [CNT_BITS-1:0]     wr_cnt_q, wr_cnt_d;
  logic [CNT_BITS-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0]     sent_q, sent_d;
  logic                    overflow_q, overflow_d;
  logic                    start_err_q, start_err_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    ctrl_we_s, pix_we_s, start_s, clear_s;
  logic                    streaming_s, accept_s, loaded_s;
  logic [LANES-1:0]        lane_we_s;
  logic [IMG_ADR_BITS-1:0] lane_addr_s [LANES];
  logic [SUM_BITS-1:0]     wr_sum_s;
  logic                    unused_ok_s;

  assign ctrl_we_s   = bus.avs_write_i & (bus.avs_address_i == REG_CTRL);
  assign pix_we_s    = bus.avs_write_i & (bus.avs_address_i == REG_PIXEL);
  assign start_s     = ctrl_we_s & bus.avs_writedata_i[0];
  assign clear_s     = ctrl_we_s & bus.avs_writedata_i[1];
  assign streaming_s = (state_q == ST_STREAM);
  assign accept_s    = streaming_s & bus.dataAck_i;
  assign loaded_s    = (wr_cnt_q == N_C);
  // Upper write-data bits carry no meaning in single-pixel builds.
  assign unused_ok_s = ^bus.avs_writedata_i[31:8];

  // Per-lane buffer address/enable for a PIXEL write; lanes past the frame end are dropped.
  always_comb begin
    lane_we_s = {LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      lane_addr_s[k] = IMG_ADR_BITS'(SUM_BITS'(wr_cnt_q) + SUM_BITS'(k));
      if (pix_we_s && (state_q == ST_IDLE) &&
          ((SUM_BITS'(wr_cnt_q) + SUM_BITS'(k)) < N_SUM)) begin
        lane_we_s[k] = 1'b1;
      end else begin
        lane_we_s[k] = 1'b0;
      end
    end
    wr_sum_s = SUM_BITS'(wr_cnt_q) + SUM_BITS'(LANES);
  end

  // Control FSM and counters; CLEAR overrides everything else in the same write.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    sent_d      = sent_q;
    overflow_d  = overflow_q;
    start_err_d = start_err_q;
    if (clear_s) begin
      state_d     = ST_IDLE;
      wr_cnt_d    = ZERO_C;
      rd_ptr_d    = ZERO_C;
      sent_d      = ZERO_C;
      overflow_d  = 1'b0;
      start_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pix_we_s) begin
            if (wr_sum_s > N_SUM) begin
              overflow_d = 1'b1;
              wr_cnt_d   = N_C;
            end else begin
              wr_cnt_d   = CNT_BITS'(wr_sum_s);
            end
          end else begin
            wr_cnt_d = wr_cnt_q;
          end
          if (start_s) begin
            if (loaded_s) begin
              state_d     = ST_STREAM;
              rd_ptr_d    = ZERO_C;
              sent_d      = ZERO_C;
              start_err_d = 1'b0;
            end else begin
              start_err_d = 1'b1;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_STREAM: begin
          if (pix_we_s) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          if (accept_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
            sent_d   = sent_q + ONE_C;
            if (rd_ptr_q == LAST_C) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_STREAM;
            end
          end else begin
            rd_ptr_d = rd_ptr_q;
          end
        end
        ST_DONE: begin
          if (pix_we_s) begin
            overflow_d = 1'b1;
          end else begin
            overflow_d = overflow_q;
          end
          if (start_s) begin
            state_d  = ST_STREAM;
            rd_ptr_d = ZERO_C;
            sent_d   = ZERO_C;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Register read mux; the read data is captured only on a read strobe and held otherwise.
  always_comb begin
    rdata_d = rdata_q;
    if (bus.avs_read_i) begin
      case (bus.avs_address_i)
        REG_STATUS: rdata_d = {16'(wr_cnt_q), 11'b0, start_err_q, overflow_q,
                               loaded_s, (state_q == ST_DONE), streaming_s};
        REG_SENT:   rdata_d = 32'(sent_q);
        default:    rdata_d = 32'h0000_0000;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // State, counter, flag and read-data registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      wr_cnt_q    <= ZERO_C;
      rd_ptr_q    <= ZERO_C;
      sent_q      <= ZERO_C;
      overflow_q  <= 1'b0;
      start_err_q <= 1'b0;
      rdata_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      sent_q      <= sent_d;
      overflow_q  <= overflow_d;
      start_err_q <= start_err_d;
      rdata_q     <= rdata_d;
    end
  end

  // Frame buffer write port; contents deliberately survive reset and CLEAR.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < LANES; k++) begin
      if (lane_we_s[k]) begin
        mem[lane_addr_s[k]] <= bus.avs_writedata_i[8*k +: 8];
      end
    end
  end

  assign bus.dataAvailable_o = streaming_s;
  assign bus.GrayImg_o       = streaming_s ? mem[rd_ptr_q[IMG_ADR_BITS-1:0]] : 8'h00;
  assign bus.frameStart_o    = streaming_s & (rd_ptr_q == ZERO_C);
  assign bus.frameEnd_o      = streaming_s & (rd_ptr_q == LAST_C);
  assign bus.avs_readdata_o  = rdata_q;

endmodule

// File: tb/tb_edge_pixel_streamer.sv
// Self-checking bench for edge_pixel_streamer on a 4x4 frame. A transaction
// level model (pixel array, write count, sent count, flags) predicts every
// register read and every offered pixel. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_edge_pixel_streamer;

  localparam int NP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_pixel_streamer_if bus ();

  edge_pixel_streamer #(.IMG_X_SIZE(4), .IMG_Y_SIZE(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  int m_mem [NP];
  int m_wr, m_sent, m_idx;
  bit m_ovf, m_serr, m_stream, m_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_sent = 0; m_idx = 0;
    m_ovf = 1'b0; m_serr = 1'b0; m_stream = 1'b0; m_done = 1'b0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address_i   = a;
    bus.avs_writedata_i = d;
    bus.avs_write_i     = 1'b1;
    @(posedge clk); #1;
    bus.avs_write_i     = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address_i = a;
    bus.avs_read_i    = 1'b1;
    @(posedge clk); #1;
    bus.avs_read_i    = 1'b0;
    d = bus.avs_readdata_o;
  endtask

  task automatic pix_wr(input logic [31:0] d);
    bus_wr(2'd2, d);
    if (m_stream || m_done) begin
      m_ovf = 1'b1;
    end else begin
`ifdef EDGE_STREAMER_PACK4_EN
      if (m_wr == NP) m_ovf = 1'b1;
      else begin
        for (int k = 0; k < 4; k++) begin
          if (m_wr < NP) begin m_mem[m_wr] = int'(d[8*k +: 8]); m_wr++; end
          else m_ovf = 1'b1;
        end
      end
`else
      if (m_wr < NP) begin m_mem[m_wr] = int'(d[7:0]); m_wr++; end
      else m_ovf = 1'b1;
`endif
    end
  endtask

  task automatic ctrl(input bit start, input bit clear);
    bus_wr(2'd0, {30'($urandom), clear, start});
    if (clear) model_reset();
    else if (start) begin
      if (m_stream) begin end
      else if (m_done) begin m_stream = 1'b1; m_done = 1'b0; m_idx = 0; m_sent = 0; end
      else if (m_wr == NP) begin m_stream = 1'b1; m_idx = 0; m_sent = 0; m_serr = 1'b0; end
      else m_serr = 1'b1;
    end
  endtask

  task automatic load_rand(input int npix);
`ifdef EDGE_STREAMER_PACK4_EN
    repeat ((npix + 3) / 4) pix_wr($urandom);
`else
    repeat (npix) pix_wr($urandom);
`endif
  endtask

  // frame of pixel values 0..15 followed by one extra (overflowing) write
  task automatic load_ramp();
`ifdef EDGE_STREAMER_PACK4_EN
    for (int w = 0; w < 4; w++) pix_wr(32'h0302_0100 + 32'(w) * 32'h0404_0404);
    pix_wr(32'h1312_1110);
`else
    for (int i = 0; i < NP; i++) pix_wr(32'hA5A5_A500 | 32'(i));
    pix_wr(32'h0000_0077);
`endif
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] d;
    logic [31:0] exp;
    exp = {16'(m_wr), 11'b0, m_serr, m_ovf, (m_wr == NP), m_done, m_stream};
    bus_rd(2'd1, d);
    chk({tag, "_status"}, d, exp);
    @(posedge clk); #1;
    chk({tag, "_status_hold"}, bus.avs_readdata_o, exp);
    bus_rd(2'd3, d);
    chk({tag, "_sent"}, d, 32'(m_sent));
  endtask

  task automatic run_stream(input int mode, input int max_acc);
    int  acc = 0;
    int  cyc = 0;
    logic ack;
    while (m_stream && acc < max_acc && cyc < 200) begin
      case (mode)
        0:       ack = 1'b1;
        1:       ack = ((cyc % 3) == 0);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      bus.dataAck_i = ack;
      @(negedge clk);
      chk("avail",  32'(bus.dataAvailable_o), 32'd1);
      chk("pixel",  32'(bus.GrayImg_o),       32'(m_mem[m_idx]));
      chk("fstart", 32'(bus.frameStart_o),    32'(m_idx == 0));
      chk("fend",   32'(bus.frameEnd_o),      32'(m_idx == NP - 1));
      @(posedge clk); #1;
      if (ack) begin
        m_idx++; m_sent++; acc++;
        if (m_idx == NP) begin m_stream = 1'b0; m_done = 1'b1; end
      end
      cyc++;
    end
    bus.dataAck_i = 1'b0;
    if (cyc >= 200) chk("stream_budget", 32'(cyc), 32'd0);
    @(negedge clk);
    chk("avail_after", 32'(bus.dataAvailable_o), 32'(m_stream));
    @(posedge clk); #1;
  endtask

  // reset with ack held high: nothing may be offered during or after it
  task automatic do_reset();
    rst = 1'b1;
    bus.dataAck_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_avail",  32'(bus.dataAvailable_o), 32'd0);
    chk("rst_fstart", 32'(bus.frameStart_o),    32'd0);
    chk("rst_fend",   32'(bus.frameEnd_o),      32'd0);
    chk("rst_rdata",  bus.avs_readdata_o,       32'd0);
    @(posedge clk); #1;
    bus.dataAck_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.avs_address_i   = 2'd0;
    bus.avs_write_i     = 1'b0;
    bus.avs_writedata_i = 32'd0;
    bus.avs_read_i      = 1'b0;
    bus.dataAck_i       = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    check_regs("reset");

    // START guard, then overflow while filling
    load_rand(10);
    ctrl(1'b1, 1'b0);
    bus.dataAck_i = 1'b1;
    @(negedge clk);
    chk("serr_no_avail", 32'(bus.dataAvailable_o), 32'd0);
    @(posedge clk); #1;
    bus.dataAck_i = 1'b0;
    check_regs("serr");
    load_rand(7);
    check_regs("ovf");

    // full stream, constant ack
    ctrl(1'b1, 1'b0);
    run_stream(0, NP);
    check_regs("done1");

    // restart from DONE with backpressure 1,0,0
    ctrl(1'b1, 1'b0);
    run_stream(1, NP);
    check_regs("done2");

    // CLEAR mid-stream (with START in the same write)
    ctrl(1'b0, 1'b1);
    load_ramp();
    ctrl(1'b1, 1'b0);
    run_stream(2, 5);
    ctrl(1'b1, 1'b1);
    @(negedge clk);
    chk("clr_avail", 32'(bus.dataAvailable_o), 32'd0);
    @(posedge clk); #1;
    check_regs("clear");

    // ramp frame 0..15 with constant ack
    load_ramp();
    check_regs("ramp_load");
    ctrl(1'b1, 1'b0);
    run_stream(0, NP);
    check_regs("ramp_done");

    // random frame, START while streaming is ignored, then reset mid-stream
    ctrl(1'b0, 1'b1);
    load_rand(16);
    ctrl(1'b1, 1'b0);
    run_stream(2, 6);
    ctrl(1'b1, 1'b0);
    run_stream(2, 3);
    check_regs("mid");
    do_reset();
    check_regs("rst_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
